// File: rtl/vx_result_gather_pkg.sv
// Shared types for the result gather stage: FSM states and result header.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

package VX_gpu_pkg;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_ACCUM = 2'd1,
    GS_FULL  = 2'd2
  } gather_state_e;

  typedef struct packed {
    logic [`UUID_WIDTH-1:0] uuid;
    logic [`NW_WIDTH-1:0]   wid;
    logic [`XLEN-1:0]       PC;
    logic                   wb;
    logic [`NR_BITS-1:0]    rd;
  } gather_hdr_t;

endpackage

// File: rtl/vx_result_gather_lane_merge.sv
// Combinational merge of one lane packet into the thread-wide buffer.
module vx_gather_lane_merge
  import VX_gpu_pkg::*;
#(
  parameter int NUM_LANES   = 1,
  parameter int THREAD_CNT  = 4,
  parameter int NUM_PACKETS = 4,
  parameter int PID_WIDTH   = 2,
  parameter int XLEN        = 32
) (
  input  logic [THREAD_CNT-1:0]      buf_tmask,
  input  logic [THREAD_CNT*XLEN-1:0] buf_data,
  input  logic [NUM_LANES-1:0]       pkt_tmask,
  input  logic [NUM_LANES*XLEN-1:0]  pkt_data,
  input  logic [PID_WIDTH-1:0]       pid,
  output logic [THREAD_CNT-1:0]      nxt_tmask,
  output logic [THREAD_CNT*XLEN-1:0] nxt_data
);

  always_comb begin
    nxt_tmask = buf_tmask;
    nxt_data  = buf_data;
    // out-of-range pids match no slot, so their lanes are dropped
    for (int p = 0; p < NUM_PACKETS; p++) begin
      if (int'(pid) == p) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (p * NUM_LANES + l < THREAD_CNT) begin
            nxt_tmask[p*NUM_LANES+l] =
              buf_tmask[p*NUM_LANES+l] | pkt_tmask[l];
            if (pkt_tmask[l]) begin
              nxt_data[(p*NUM_LANES+l)*XLEN +: XLEN] =
                pkt_data[l*XLEN +: XLEN];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/vx_result_gather.sv
// Gathers per-instruction lane packets into one registered commit result.
// Define VX_GATHER_CHECK_EN to enable the sticky protocol error flag.
module vx_result_gather
  import VX_gpu_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int THREAD_CNT = `NUM_THREADS,
  localparam int NUM_PACKETS =
    (THREAD_CNT / NUM_LANES) > 0 ? (THREAD_CNT / NUM_LANES) : 1,
  localparam int PID_WIDTH =
    NUM_PACKETS > 1 ? $clog2(NUM_PACKETS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [`UUID_WIDTH-1:0]      in_uuid,
  input  logic [`NW_WIDTH-1:0]        in_wid,
  input  logic [`XLEN-1:0]            in_PC,
  input  logic                        in_wb,
  input  logic [`NR_BITS-1:0]         in_rd,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [NUM_LANES*`XLEN-1:0]  in_data,
  input  logic [PID_WIDTH-1:0]        in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [`UUID_WIDTH-1:0]      out_uuid,
  output logic [`NW_WIDTH-1:0]        out_wid,
  output logic [`XLEN-1:0]            out_PC,
  output logic                        out_wb,
  output logic [`NR_BITS-1:0]         out_rd,
  output logic [THREAD_CNT-1:0]       out_tmask,
  output logic [THREAD_CNT*`XLEN-1:0] out_data,
  output logic                        err
);

  localparam bit SINGLE = (NUM_PACKETS == 1);

  gather_state_e state_q, state_d, st_eff;
  gather_hdr_t   hdr_q, hdr_d;
  logic [THREAD_CNT-1:0]       tmask_q, tmask_d, base_tmask, mrg_tmask;
  logic [THREAD_CNT*`XLEN-1:0] data_q, data_d, base_data, mrg_data;
  logic [PID_WIDTH-1:0]        pid_eff;
  logic in_fire, sop_eff, eop_eff;

  assign in_ready = (state_q != GS_FULL) | out_ready;
  assign in_fire  = in_valid & in_ready;

  // an accepted packet in FULL implies the result was consumed
  assign st_eff  = (state_q == GS_FULL) ? GS_IDLE : state_q;
  assign sop_eff = SINGLE | in_sop | (st_eff == GS_IDLE);
  assign eop_eff = SINGLE | in_eop;
  assign pid_eff = SINGLE ? '0 : in_pid;

  assign base_tmask = sop_eff ? '0 : tmask_q;
  assign base_data  = sop_eff ? '0 : data_q;

  vx_gather_lane_merge #(
    .NUM_LANES   (NUM_LANES),
    .THREAD_CNT  (THREAD_CNT),
    .NUM_PACKETS (NUM_PACKETS),
    .PID_WIDTH   (PID_WIDTH),
    .XLEN        (`XLEN)
  ) u_merge (
    .buf_tmask (base_tmask),
    .buf_data  (base_data),
    .pkt_tmask (in_tmask),
    .pkt_data  (in_data),
    .pid       (pid_eff),
    .nxt_tmask (mrg_tmask),
    .nxt_data  (mrg_data)
  );

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    tmask_d = tmask_q;
    data_d  = data_q;
    if (in_fire) begin
      state_d = eop_eff ? GS_FULL : GS_ACCUM;
      tmask_d = mrg_tmask;
      data_d  = mrg_data;
      if (sop_eff) begin
        hdr_d = '{uuid: in_uuid, wid: in_wid, PC: in_PC,
                  wb: in_wb, rd: in_rd};
      end
    end else if (state_q == GS_FULL && out_ready) begin
      state_d = GS_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= GS_IDLE;
      hdr_q   <= '0;
      tmask_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      tmask_q <= tmask_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == GS_FULL);
  assign out_uuid  = hdr_q.uuid;
  assign out_wid   = hdr_q.wid;
  assign out_PC    = hdr_q.PC;
  assign out_wb    = hdr_q.wb;
  assign out_rd    = hdr_q.rd;
  assign out_tmask = tmask_q;
  assign out_data  = data_q;

`ifdef VX_GATHER_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (in_fire && !SINGLE) begin
      if (st_eff == GS_IDLE && !in_sop) err_d = 1'b1;
      if (st_eff == GS_ACCUM && in_sop) err_d = 1'b1;
      if (int'(in_pid) >= NUM_PACKETS) err_d = 1'b1;
      if (st_eff == GS_ACCUM && !in_sop &&
          (in_wid != hdr_q.wid || in_uuid != hdr_q.uuid)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vx_result_gather.sv
// Self-checking bench for vx_result_gather (2-packet and 1-packet builds).
module tb_vx_result_gather;
  import VX_gpu_pkg::*;

  localparam int XL = `XLEN;
  localparam int CW = 4 * XL;
`ifdef VX_GATHER_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // instance A: THREAD_CNT=4, NUM_LANES=2
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
  logic [`UUID_WIDTH-1:0] a_in_uuid, a_out_uuid;
  logic [`NW_WIDTH-1:0] a_in_wid, a_out_wid;
  logic [XL-1:0] a_in_pc, a_out_pc;
  logic a_in_wb, a_out_wb;
  logic [`NR_BITS-1:0] a_in_rd, a_out_rd;
  logic [1:0] a_in_tmask;
  logic [2*XL-1:0] a_in_data;
  logic [0:0] a_in_pid;
  logic a_in_sop, a_in_eop;
  logic [3:0] a_out_tmask;
  logic [CW-1:0] a_out_data;

  // instance B: THREAD_CNT=4, NUM_LANES=4 (single packet)
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
  logic [`UUID_WIDTH-1:0] b_out_uuid;
  logic [`NW_WIDTH-1:0] b_out_wid;
  logic [XL-1:0] b_out_pc;
  logic b_out_wb;
  logic [`NR_BITS-1:0] b_out_rd;
  logic [3:0] b_in_tmask, b_out_tmask;
  logic [CW-1:0] b_in_data, b_out_data;
  logic [0:0] b_in_pid;
  logic b_in_sop, b_in_eop;

  vx_result_gather #(.NUM_LANES(2), .THREAD_CNT(4)) u_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_uuid(a_in_uuid), .in_wid(a_in_wid), .in_PC(a_in_pc),
    .in_wb(a_in_wb), .in_rd(a_in_rd),
    .in_tmask(a_in_tmask), .in_data(a_in_data),
    .in_pid(a_in_pid), .in_sop(a_in_sop), .in_eop(a_in_eop),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_uuid(a_out_uuid), .out_wid(a_out_wid), .out_PC(a_out_pc),
    .out_wb(a_out_wb), .out_rd(a_out_rd),
    .out_tmask(a_out_tmask), .out_data(a_out_data), .err(a_err)
  );

  vx_result_gather #(.NUM_LANES(4), .THREAD_CNT(4)) u_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_uuid('0), .in_wid('0), .in_PC('0),
    .in_wb(1'b0), .in_rd('0),
    .in_tmask(b_in_tmask), .in_data(b_in_data),
    .in_pid(b_in_pid), .in_sop(b_in_sop), .in_eop(b_in_eop),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_uuid(b_out_uuid), .out_wid(b_out_wid), .out_PC(b_out_pc),
    .out_wb(b_out_wb), .out_rd(b_out_rd),
    .out_tmask(b_out_tmask), .out_data(b_out_data), .err(b_err)
  );

  task automatic chk(input string name, input logic [CW-1:0] act,
                     input logic [CW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input bit v, input bit sop, input bit eop,
                         input bit pid, input logic [1:0] tm,
                         input logic [XL-1:0] d0, input logic [XL-1:0] d1,
                         input int uuid, input bit ordy);
    a_in_valid  = v;
    a_in_sop    = sop;
    a_in_eop    = eop;
    a_in_pid    = pid;
    a_in_tmask  = tm;
    a_in_data   = {d1, d0};
    a_in_uuid   = `UUID_WIDTH'(uuid);
    a_in_wid    = `NW_WIDTH'(uuid);
    a_in_pc     = XL'(32'h1000 + uuid * 4);
    a_in_wb     = 1'b1;
    a_in_rd     = `NR_BITS'(uuid);
    a_out_ready = ordy;
  endtask

  typedef struct {
    bit sop, eop, pid;
    logic [1:0] tm;
    logic [XL-1:0] d0, d1;
    int uuid;
    bit ev;
    logic [3:0] etm;
    logic [CW-1:0] ed;
  } vec_t;

  localparam logic [XL-1:0] Z = '0;
  localparam logic [XL-1:0] J = XL'(32'hDEAD_BEEF);

  vec_t vt[8];
  bit mfull, bfull, exp_rdy, v, ordy;
  logic [3:0] am, rm, bm;
  logic [CW-1:0] ad, rdat, bd;
  logic [1:0] tm;
  logic [XL-1:0] d0, d1;
  int gpid, guid;

  initial begin
    a_drive(0, 0, 0, 0, 2'b00, Z, Z, 0, 1'b1);
    b_in_valid = 0; b_out_ready = 1; b_in_pid = '0;
    b_in_sop = 0; b_in_eop = 0; b_in_tmask = '0; b_in_data = '0;

    vt[0] = '{1,0,0,2'b11,XL'(32'hA),XL'(32'hB),1,0,4'b0000,'0};
    vt[1] = '{0,1,1,2'b01,XL'(32'hC),J,1,1,4'b0111,
              {Z,XL'(32'hC),XL'(32'hB),XL'(32'hA)}};
    vt[2] = '{1,0,0,2'b10,J,XL'(32'hE),2,0,4'b0000,'0};
    vt[3] = '{0,1,1,2'b11,XL'(32'hF),XL'(32'h10),2,1,4'b1110,
              {XL'(32'h10),XL'(32'hF),XL'(32'hE),Z}};
    vt[4] = '{1,0,0,2'b01,XL'(32'h11),J,3,0,4'b0000,'0};
    vt[5] = '{0,1,1,2'b10,J,XL'(32'h12),3,1,4'b1001,
              {XL'(32'h12),Z,Z,XL'(32'h11)}};
    vt[6] = '{1,0,0,2'b00,J,J,4,0,4'b0000,'0};
    vt[7] = '{0,1,1,2'b11,XL'(32'h13),XL'(32'h14),4,1,4'b1100,
              {XL'(32'h14),XL'(32'h13),Z,Z}};

    // reset state
    #3;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_tmask", a_out_tmask, 0);
    chk("rst_a_data", a_out_data, 0);
    chk("rst_a_uuid", a_out_uuid, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_valid", b_out_valid, 0);
    #9 reset = 1'b1;
    tick();

    // table: gather + back-to-back instructions
    for (int i = 0; i < 8; i++) begin
      a_drive(1, vt[i].sop, vt[i].eop, vt[i].pid, vt[i].tm,
              vt[i].d0, vt[i].d1, vt[i].uuid, 1'b1);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), a_in_ready, 1);
      tick();
      chk($sformatf("tbl%0d_valid", i), a_out_valid, vt[i].ev);
      if (vt[i].ev) begin
        chk($sformatf("tbl%0d_tmask", i), a_out_tmask, vt[i].etm);
        chk($sformatf("tbl%0d_data", i), a_out_data, vt[i].ed);
        chk($sformatf("tbl%0d_uuid", i), a_out_uuid, vt[i].uuid);
        chk($sformatf("tbl%0d_pc", i), a_out_pc,
            XL'(32'h1000 + vt[i].uuid * 4));
      end
    end

    // backpressure: output held, input blocked
    a_drive(1, 1, 0, 0, 2'b11, XL'(32'h21), XL'(32'h22), 5, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_in_ready", a_in_ready, 0);
      chk("stall_valid", a_out_valid, 1);
      chk("stall_data", a_out_data, vt[7].ed);
      chk("stall_uuid", a_out_uuid, 4);
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    chk("release_in_ready", a_in_ready, 1);
    chk("release_out_valid", a_out_valid, 1);
    tick();
    chk("release_consumed", a_out_valid, 0);
    a_drive(1, 0, 1, 1, 2'b11, XL'(32'h23), XL'(32'h24), 5, 1'b1);
    tick();
    chk("release_res_valid", a_out_valid, 1);
    chk("release_res_data", a_out_data,
        {XL'(32'h24), XL'(32'h23), XL'(32'h22), XL'(32'h21)});
    chk("release_err", a_err, 0);

    // sop while accumulating restarts the gather
    a_drive(1, 1, 0, 0, 2'b11, XL'(32'h31), XL'(32'h32), 6, 1'b1);
    tick();
    a_drive(1, 1, 0, 0, 2'b01, XL'(32'h33), J, 7, 1'b1);
    tick();
    a_drive(1, 0, 1, 1, 2'b10, J, XL'(32'h34), 7, 1'b1);
    tick();
    chk("restart_valid", a_out_valid, 1);
    chk("restart_tmask", a_out_tmask, 4'b1001);
    chk("restart_data", a_out_data, {XL'(32'h34), Z, Z, XL'(32'h33)});
    chk("restart_uuid", a_out_uuid, 7);
    chk("restart_err", a_err, EXP_ERR);

    // asynchronous reset while a partial is held
    a_drive(1, 1, 0, 0, 2'b11, XL'(32'h41), XL'(32'h42), 8, 1'b1);
    tick();
    chk("pre_rst_tmask", a_out_tmask, 4'b0011);
    a_in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", a_out_valid, 0);
    chk("async_rst_tmask", a_out_tmask, 0);
    chk("async_rst_data", a_out_data, 0);
    chk("async_rst_uuid", a_out_uuid, 0);
    chk("async_rst_err", a_err, 0);
    #2 reset = 1'b1;
    tick();
    a_drive(1, 1, 0, 0, 2'b01, XL'(32'h51), J, 9, 1'b1);
    tick();
    a_drive(1, 0, 1, 1, 2'b01, XL'(32'h52), J, 9, 1'b1);
    tick();
    chk("post_rst_valid", a_out_valid, 1);
    chk("post_rst_tmask", a_out_tmask, 4'b0101);
    chk("post_rst_data", a_out_data, {Z, XL'(32'h52), Z, XL'(32'h51)});
    a_drive(0, 0, 0, 0, 2'b00, Z, Z, 0, 1'b1);
    tick();

    // random well-formed 2-packet traffic vs per-thread model
    mfull = 0; am = '0; ad = '0; rm = '0; rdat = '0;
    gpid = 0; guid = 20;
    for (int c = 0; c < 300; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      tm   = 2'($urandom);
      d0   = XL'($urandom);
      d1   = XL'($urandom);
      a_drive(v, gpid == 0, gpid == 1, gpid[0], tm, d0, d1, guid, ordy);
      #1;
      exp_rdy = !mfull || ordy;
      chk("rndA_in_ready", a_in_ready, exp_rdy);
      chk("rndA_valid", a_out_valid, mfull);
      if (mfull) begin
        chk("rndA_tmask", a_out_tmask, rm);
        chk("rndA_data", a_out_data, rdat);
      end
      if (mfull && ordy) mfull = 0;
      if (v && exp_rdy) begin
        if (gpid == 0) begin am = '0; ad = '0; end
        for (int l = 0; l < 2; l++) begin
          if (tm[l]) begin
            am[gpid*2+l] = 1'b1;
            ad[(gpid*2+l)*XL +: XL] = (l == 0) ? d0 : d1;
          end
        end
        if (gpid == 1) begin
          mfull = 1; rm = am; rdat = ad; guid++;
        end
        gpid ^= 1;
      end
      tick();
    end
    chk("rndA_err", a_err, 0);

    // single-packet build: every accepted packet is a full result
    bfull = 0; bm = '0; bd = '0;
    for (int c = 0; c < 300; c++) begin
      v = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      b_in_valid  = v;
      b_out_ready = ordy;
      b_in_pid    = 1'($urandom);
      b_in_sop    = 1'($urandom);
      b_in_eop    = 1'($urandom);
      b_in_tmask  = 4'($urandom);
      for (int t = 0; t < 4; t++) b_in_data[t*XL +: XL] = XL'($urandom);
      #1;
      exp_rdy = !bfull || ordy;
      chk("rndB_in_ready", b_in_ready, exp_rdy);
      chk("rndB_valid", b_out_valid, bfull);
      if (bfull) begin
        chk("rndB_tmask", b_out_tmask, bm);
        chk("rndB_data", b_out_data, bd);
      end
      if (bfull && ordy) bfull = 0;
      if (v && exp_rdy) begin
        bfull = 1;
        bm = b_in_tmask;
        for (int t = 0; t < 4; t++)
          bd[t*XL +: XL] = b_in_tmask[t] ? b_in_data[t*XL +: XL] : Z;
      end
      tick();
    end
    chk("rndB_err", b_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_result_gather.md
# vx_result_gather

Commit-side reassembly stage that sits directly downstream of the dispatch unit's execute path, at the output of each execute unit. It collects the NUM_LANES-wide result packets that one instruction produced (tagged pid/sop/eop) and merges them into one THREAD_CNT-wide result. It then presents that result as a single registered commit transaction. Packets of one instruction arrive in order, sop first and eop last, and are never interleaved with packets of another instruction.

## Interface
- NUM_LANES, 1, lanes per input packet; must divide THREAD_CNT
- THREAD_CNT, `NUM_THREADS, threads per output result
- NUM_PACKETS, THREAD_CNT/NUM_LANES (derived, floor 1), packets per full result
- PID_WIDTH, max(1, clog2(NUM_PACKETS)) (derived)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low; asserted when 0
- in_valid  input  1  packet valid
- in_ready  output  1  packet accepted when in_valid & in_ready
- in_uuid / in_wid / in_PC / in_wb / in_rd  input  `UUID_WIDTH / `NW_WIDTH / `XLEN / 1 / `NR_BITS  instruction header
- in_tmask  input  NUM_LANES  lane mask of this packet
- in_data  input  NUM_LANES*`XLEN  lane results
- in_pid / in_sop / in_eop  input  PID_WIDTH / 1 / 1  packet id, first packet, last packet
- out_valid  output  1  full result valid
- out_ready  input  1  consumer ready
- out_uuid / out_wid / out_PC / out_wb / out_rd  output  as inputs  captured header
- out_tmask  output  THREAD_CNT  merged mask
- out_data  output  THREAD_CNT*`XLEN  merged results; inactive threads read 0
- err  output  1  sticky protocol error (see Configuration)

## Operation
- State machine: IDLE (no partial), ACCUM (partial held), FULL (out_valid=1).
- in_ready = (state != FULL) | out_ready.
- Accepted sop packet: clear the whole tmask and data buffer, capture the header, then write the packet.
- Write rule: lanes go to threads [pid*NUM_LANES +: NUM_LANES]. tmask bits are ORed in. Data is written only for lanes whose in_tmask bit is set.
- Accepted packet with eop=0: next state ACCUM. Accepted packet with eop=1: next state FULL.
- FULL with out_ready=1 and no accepted input: next state IDLE.
- FULL with out_ready=1 and an accepted packet in the same cycle: the result is consumed; the new packet is processed per the rules above. It must be sop; otherwise the non-sop rule applies.
- Non-sop packet accepted in IDLE: treated as sop (buffer cleared, header captured).
- sop packet accepted in ACCUM: the partial result is discarded and accumulation restarts.
- pid >= NUM_PACKETS: packet accepted, data dropped, state advances per eop.
- NUM_PACKETS == 1: pid ignored; every accepted packet behaves as sop & eop.
- Reset (async, mid-operation allowed): state IDLE, out_valid=0, out_tmask=0, out_data=0, header registers 0, err=0. Any partial result is lost.

## Timing
- Output registered: eop accepted at edge N gives out_valid=1 from N+1.
- Minimum latency 1 cycle per instruction.
- Sustained throughput: one packet per cycle. One result every NUM_PACKETS cycles, with no bubble between back-to-back instructions while out_ready=1.
- out_* stay stable while out_valid & ~out_ready.
- No combinational path from in_* to out_*. Combinational path out_ready to in_ready is permitted.

## Configuration
- VX_GATHER_CHECK_EN defined: err is set, and stays set until reset, on any of the following:
  - non-sop packet accepted in IDLE
  - sop packet accepted in ACCUM
  - pid >= NUM_PACKETS
  - wid or uuid differs from the captured header on a non-sop packet in ACCUM
- VX_GATHER_CHECK_EN undefined: err tied 0, no check logic. Datapath behaviour is identical in both cases.

## Structure
- Shared package (VX_gpu_pkg): gather state enum (IDLE/ACCUM/FULL) and a result-header struct (uuid, wid, PC, wb, rd).
- One sub-module: vx_gather_lane_merge. It is combinational: buffer, packet and pid in, next tmask/data out. It is instantiated once.

## Test plan
- THREAD_CNT=4, NUM_LANES=2, out_ready=1. Send pid0 sop tmask=11 data{A,B}, then pid1 eop tmask=01 data{C,x}. Required: one cycle later out_tmask=0111, out_data={0,C,B,A}.
- Same configuration, out_ready=0 for 5 cycles after FULL. Required: in_ready=0, outputs stable. Raise out_ready with a new sop packet valid: both transfers occur on the same edge.
- Back-to-back: 3 instructions, 2 packets each, out_ready=1. Required: 3 results on cycles 2, 4, 6 after the first accept, with no gaps.
- sop arrives in ACCUM. Required: the old partial is discarded, the output holds only the new instruction's data, and err=1 with VX_GATHER_CHECK_EN defined, 0 without.
- reset asserted while in ACCUM. Required: out_valid=0 and state IDLE immediately (asynchronously); after release a fresh 2-packet instruction gathers correctly.
- NUM_PACKETS=1 with random pid/sop/eop values. Required: every accepted packet produces one output the next cycle, with out_data equal to in_data masked by in_tmask.
